// File: rtl/ysyx_23060201_wbu.sv
// Write-back unit: accepts one retiring instruction per handshake, waits for load data,
// extends the load lane and pulses the GPR write port. Optional memory-wait timeout
// is enabled by defining YSYX_23060201_WBU_TIMEOUT_EN.
module ysyx_23060201_wbu #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_wen,
  input  logic                      in_is_load,
  input  logic [2:0]                in_funct3,
  input  logic [1:0]                in_addr_lo,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      retire,
  output logic                      mem_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t                    state, state_nxt;
  logic [GPR_ADDR_WIDTH-1:0] rd_q;
  logic                      wen_q;
  logic [2:0]                funct3_q;
  logic [1:0]                addr_lo_q;

  logic                      accept;
  logic                      timeout_hit;
  logic                      wb_fire, wb_timeout, wb_wen;
  logic [GPR_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data, load_data;
  logic [7:0]                byte_lane;
  logic [15:0]               half_lane;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  assign byte_lane = mem_rdata[8*addr_lo_q +: 8];
  assign half_lane = mem_rdata[16*addr_lo_q[1] +: 16];

  always_comb begin
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  // wb_* describe the write that becomes visible on the cycle after this edge
  always_comb begin
    state_nxt  = state;
    wb_fire    = 1'b0;
    wb_timeout = 1'b0;
    wb_rd      = rd_q;
    wb_wen     = wen_q;
    wb_data    = load_data;
    case (state)
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_nxt = WRITE;
          wb_fire   = 1'b1;
        end else if (timeout_hit) begin
          state_nxt  = WRITE;
          wb_fire    = 1'b1;
          wb_timeout = 1'b1;
          wb_wen     = 1'b0;
          wb_data    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        if (accept) begin
          if (in_is_load) begin
            state_nxt = WAIT_MEM;
          end else begin
            state_nxt = WRITE;
            wb_fire   = 1'b1;
            wb_rd     = in_rd;
            wb_wen    = in_rd_wen;
            wb_data   = in_result;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      retire    <= 1'b0;
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      state   <= state_nxt;
      retire  <= wb_fire;
      gpr_wen <= wb_fire && wb_wen && (wb_rd != '0);
      if (accept) begin
        rd_q      <= in_rd;
        wen_q     <= in_rd_wen;
        funct3_q  <= in_funct3;
        addr_lo_q <= in_addr_lo;
      end
      // address/data hold their last written value across non-writing retires
      if (wb_fire && wb_wen && (wb_rd != '0)) begin
        gpr_waddr <= wb_rd;
        gpr_wdata <= wb_data;
      end else if (wb_timeout) begin
        gpr_wdata <= '0;
      end
    end
  end

`ifdef YSYX_23060201_WBU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign timeout_hit = (state == WAIT_MEM) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept && in_is_load)
        wait_cnt <= '0;
      else if (state == WAIT_MEM)
        wait_cnt <= wait_cnt + 1'b1;
      if (wb_timeout)
        timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // constant 0; the parameter only matters when the timeout is built in
  assign mem_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_ysyx_23060201_wbu.sv
// Bench for ysyx_23060201_wbu: directed and randomized retires checked against a
// load-extension reference model. Timeout test runs when YSYX_23060201_WBU_TIMEOUT_EN is defined.
module tb_ysyx_23060201_wbu;
`ifdef YSYX_23060201_WBU_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rd_wen, in_is_load, mem_rvalid;
  logic [4:0]  in_rd, gpr_waddr;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result, mem_rdata, gpr_wdata;
  logic        gpr_wen, retire, mem_timeout;

  int passed = 0;
  int total  = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  ysyx_23060201_wbu #(.GPR_ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_result(in_result), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .retire(retire), .mem_timeout(mem_timeout));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference load extension from the lane rules, using shifts and masks
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_is_load = 0; mem_rvalid = 0; in_rd_wen = 0;
  endtask

  // Check the write-back cycle against the expected write and the holding rule
  task automatic chk_wb(input string tag, input logic [4:0] rd, input logic wen,
                        input logic [31:0] data);
    logic w;
    w = wen && (rd != 0);
    chk({tag, ".retire"}, 32'(retire), 32'd1);
    chk({tag, ".wen"}, 32'(gpr_wen), 32'(w));
    if (w) begin
      last_addr = rd;
      last_data = data;
    end
    chk({tag, ".waddr"}, 32'(gpr_waddr), 32'(last_addr));
    chk({tag, ".wdata"}, gpr_wdata, last_data);
  endtask

  task automatic do_nonload(input string tag, input logic [4:0] rd, input logic wen,
                            input logic [31:0] res);
    in_valid = 1; in_is_load = 0; in_rd = rd; in_rd_wen = wen; in_result = res;
    in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    tick();
    idle_inputs();
    in_result = $urandom;
    chk_wb(tag, rd, wen, res);
    tick();
    chk({tag, ".wen_off"}, 32'(gpr_wen), 32'd0);
    chk({tag, ".retire_off"}, 32'(retire), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic wen,
                         input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w,
                         input int waits);
    in_valid = 1; in_is_load = 1; in_rd = rd; in_rd_wen = wen; in_funct3 = f3; in_addr_lo = a;
    mem_rvalid = 1; mem_rdata = ~w;  // valid in the accept cycle must be ignored
    tick();
    idle_inputs();
    in_rd = 5'($urandom); in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
    for (int i = 0; i < waits; i++) begin
      chk({tag, ".wait_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ".wait_wen"}, 32'(gpr_wen | retire), 32'd0);
      tick();
    end
    chk({tag, ".ready_lo"}, 32'(in_ready), 32'd0);
    mem_rvalid = 1; mem_rdata = w;
    tick();
    mem_rvalid = 0; mem_rdata = $urandom;
    chk_wb(tag, rd, wen, ref_load(w, f3, a));
    tick();
    chk({tag, ".wen_off"}, 32'(gpr_wen), 32'd0);
  endtask

  initial begin
    rst = 1; idle_inputs();
    in_rd = 0; in_funct3 = 0; in_addr_lo = 0; in_result = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.wen", 32'(gpr_wen), 32'd0);
    chk("rst.retire", 32'(retire), 32'd0);
    chk("rst.waddr", 32'(gpr_waddr), 32'd0);
    chk("rst.wdata", gpr_wdata, 32'd0);
    chk("rst.timeout", 32'(mem_timeout), 32'd0);
    rst = 0;
    tick();

    do_nonload("nl", 5'd5, 1'b1, 32'h1234_5678);
    do_nonload("x0", 5'd0, 1'b1, 32'hFFFF_FFFF);
    do_nonload("nowen", 5'd7, 1'b0, 32'hDEAD_BEEF);

    do_load("lb1", 5'd9, 1'b1, 3'b000, 2'd1, 32'h80FF_7F01, 0);
    chk("lb1.val", gpr_wdata, 32'h0000_007F);
    do_load("lb3", 5'd10, 1'b1, 3'b000, 2'd3, 32'h80FF_7F01, 2);
    chk("lb3.val", gpr_wdata, 32'hFFFF_FF80);
    do_load("lhu2", 5'd11, 1'b1, 3'b101, 2'd2, 32'h80FF_7F01, 1);
    chk("lhu2.val", gpr_wdata, 32'h0000_80FF);
    do_load("lh2", 5'd12, 1'b1, 3'b001, 2'd2, 32'h80FF_7F01, 3);
    chk("lh2.val", gpr_wdata, 32'hFFFF_80FF);
    do_load("lw", 5'd13, 1'b1, 3'b010, 2'd3, 32'hCAFE_F00D, 0);
    do_load("undef", 5'd14, 1'b1, 3'b111, 2'd1, 32'h8765_4321, 1);

    // back-to-back: valid held high three cycles
    in_valid = 1; in_is_load = 0; in_rd_wen = 1;
    for (int i = 1; i <= 3; i++) begin
      in_rd = 5'(i); in_result = 32'h100 * i;
      chk("b2b.ready", 32'(in_ready), 32'd1);
      tick();
      chk_wb("b2b", 5'(i), 1'b1, 32'h100 * i);
    end
    idle_inputs();
    tick();
    chk("b2b.end", 32'(gpr_wen), 32'd0);

    // spurious rvalid while idle
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 0;
    chk("spur.wen", 32'(gpr_wen), 32'd0);
    chk("spur.retire", 32'(retire), 32'd0);

    // reset in WAIT_MEM discards the load
    in_valid = 1; in_is_load = 1; in_rd = 5'd20; in_rd_wen = 1; in_funct3 = 3'b010;
    tick();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 0;
    chk("rstw.wen", 32'(gpr_wen), 32'd0);
    chk("rstw.retire", 32'(retire), 32'd0);
    chk("rstw.ready", 32'(in_ready), 32'd1);
    last_addr = 0; last_data = 0;
    chk("rstw.wdata", gpr_wdata, 32'd0);

    // reset beats a simultaneous accept
    rst = 1; in_valid = 1; in_is_load = 0; in_rd = 5'd3; in_rd_wen = 1; in_result = 32'h77;
    tick();
    rst = 0; idle_inputs();
    tick();
    chk("rstacc.retire", 32'(retire), 32'd0);
    chk("rstacc.wen", 32'(gpr_wen), 32'd0);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3s [5];
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      if ($urandom_range(1, 0) == 1)
        do_nonload("rnl", 5'($urandom), ($urandom_range(3, 0) != 0), $urandom);
      else
        do_load("rld", 5'($urandom), ($urandom_range(3, 0) != 0),
                f3s[$urandom_range(4, 0)], 2'($urandom), $urandom, $urandom_range(3, 0));
    end

`ifdef YSYX_23060201_WBU_TIMEOUT_EN
    in_valid = 1; in_is_load = 1; in_rd = 5'd6; in_rd_wen = 1; in_funct3 = 3'b010;
    tick();
    idle_inputs();
    for (int i = 0; i < TO - 1; i++) begin
      chk("to.wait", 32'(retire | mem_timeout), 32'd0);
      tick();
    end
    tick();
    chk("to.flag", 32'(mem_timeout), 32'd1);
    chk("to.retire", 32'(retire), 32'd1);
    chk("to.wen", 32'(gpr_wen), 32'd0);
    chk("to.wdata", gpr_wdata, 32'd0);
    tick();
    chk("to.sticky", 32'(mem_timeout), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("to.clear", 32'(mem_timeout), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_23060201_wbu.md
# ysyx_23060201_wbu

Write-back unit for the NPC core. It sits between the execute/load-store side and the general-purpose register file. It accepts one retiring instruction per handshake and, for loads, waits for the memory response. It extracts and sign- or zero-extends the load lane, then drives the register-file write port (`gpr_wen`/`gpr_waddr`/`gpr_wdata`) for exactly one cycle per instruction. Writes to x0 are suppressed at this stage, so the register file never sees a write to register 0.

## Interface
Parameters:
- `GPR_ADDR_WIDTH`, 5, register index width
- `DATA_WIDTH`, 32, data width (RV32)
- `TIMEOUT_CYCLES`, 1024, memory-wait limit (used only with the timeout macro)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  upstream holds a retiring instruction
- `in_ready`  out  1  WBU can accept this cycle
- `in_rd`  in  GPR_ADDR_WIDTH  destination register
- `in_rd_wen`  in  1  instruction writes rd
- `in_is_load`  in  1  result comes from memory
- `in_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `in_addr_lo`  in  2  load address bits [1:0]
- `in_result`  in  DATA_WIDTH  ALU/CSR/link result (non-load)
- `mem_rvalid`  in  1  load data valid
- `mem_rdata`  in  DATA_WIDTH  aligned 32-bit word containing the load
- `gpr_wen`  out  1  register-file write enable, one-cycle pulse
- `gpr_waddr`  out  GPR_ADDR_WIDTH  write index
- `gpr_wdata`  out  DATA_WIDTH  write data
- `retire`  out  1  one-cycle pulse per completed instruction, including rd=x0 and no-write instructions
- `mem_timeout`  out  1  sticky error flag (only with the timeout macro)

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE.
- `in_ready` = (state==IDLE) || (state==WRITE). It is low in WAIT_MEM.
- Accept occurs when `in_valid && in_ready`:
  - non-load: capture rd, wen and result; go to WRITE.
  - load: capture rd, wen, funct3 and addr_lo; go to WAIT_MEM.
- WAIT_MEM: on `mem_rvalid`, extend the data into the result register and go to WRITE. Otherwise stay.
- WRITE: assert `retire`, and assert `gpr_wen` = captured wen && rd!=0.
  - If a new accept occurs this cycle, go to WRITE or WAIT_MEM as for an accept from IDLE.
  - Otherwise go to IDLE.
- Load extraction:
  - byte lane = `mem_rdata[8*addr_lo +: 8]`.
  - half lane = `mem_rdata[16*addr_lo[1] +: 16]`; addr_lo[0] is ignored.
  - word ignores addr_lo.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 (011, 110, 111) writes the full word unmodified.
- `mem_rvalid` outside WAIT_MEM is ignored. This includes the accept cycle itself.
- `gpr_waddr` and `gpr_wdata` are registered and hold their last value when `gpr_wen` is low.

## Timing
- Reset values: state IDLE, `in_ready`=1, `gpr_wen`=0, `retire`=0, `gpr_waddr`=0, `gpr_wdata`=0, `mem_timeout`=0.
- Non-load latency: accept in cycle N produces `gpr_wen` in cycle N+1. Back-to-back throughput is 1 instruction/cycle.
- Load latency: accept in cycle N with `mem_rvalid` in cycle M (M≥N+1) produces `gpr_wen` in cycle M+1.
- Reset asserted in WAIT_MEM discards the pending load. A `mem_rvalid` arriving after reset is ignored.
- Reset has priority over an accept in the same cycle.
- Upstream must hold inputs stable only in the accept cycle; all fields are captured on the accepting edge.

## Configuration
- Macro `YSYX_23060201_WBU_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle.
  - On reaching `TIMEOUT_CYCLES`, `mem_timeout` sets (sticky until `rst`), and the FSM goes to WRITE with `gpr_wdata`=0 and `gpr_wen` suppressed. `retire` still pulses.
- Undefined: no counter. `mem_timeout` is tied to 0 and WAIT_MEM waits indefinitely.

## Test plan
- Non-load: rd=5, wen=1, result=0x1234_5678 accepted in cycle 3 → cycle 4 shows `gpr_wen`=1, waddr=5, wdata=0x12345678, `retire`=1; cycle 5 shows `gpr_wen`=0.
- x0 suppression: rd=0, wen=1, result=0xFFFF_FFFF → `retire`=1 with `gpr_wen`=0; rd=7, wen=0 → same response.
- Load extension:
  - mem_rdata=0x80FF_7F01 with LB at addr_lo=1 → 0x0000_007F; LB at addr_lo=3 → 0xFFFF_FF80.
  - LHU at addr_lo=2 → 0x0000_80FF; LH at addr_lo=2 → 0xFFFF_80FF.
  - `gpr_wen` is asserted the cycle after `mem_rvalid`, with `in_ready`=0 throughout the wait.
- Back-to-back: three non-load instructions with `in_valid` held high for 3 cycles → three consecutive `gpr_wen` pulses carrying rd 1, 2, 3.
- Spurious/reset: `mem_rvalid` pulsed while IDLE → no write. `rst` asserted while in WAIT_MEM, then `mem_rvalid` → no write, `in_ready`=1.
- Timeout (macro defined, `TIMEOUT_CYCLES`=8): load with no `mem_rvalid` → `mem_timeout`=1 after 8 wait cycles, `retire` pulses, `gpr_wen`=0; a subsequent `rst` clears the flag.
